jtpopeye_ps2key: RTL and testbench



---
 rtl/jtpopeye_ps2_pkg.sv | 13 +
 rtl/jtpopeye_ps2_rx.sv | 118 +++++++++++
 rtl/jtpopeye_ps2key.sv | 57 +++++
 tb/tb_jtpopeye_ps2key.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/jtpopeye_ps2_pkg.sv
// Shared constants and frame FSM state type for the PS/2 keyboard receiver.
package jtpopeye_ps2_pkg;

  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam logic [7:0] PS2_BRK        = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ps2_state_t;

endpackage

// File: rtl/jtpopeye_ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge detect,
// frame FSM with parity/stop check and an inactivity timeout.
//
// state | meaning
// IDLE  | waiting for a start bit (falling edge with data 0)
// SHIFT | collecting data, parity and stop bits; timer armed
module jtpopeye_ps2_rx
  import jtpopeye_ps2_pkg::*;
#(
  parameter int TIMEOUT = 8000,
  parameter int SYNC    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_stb,
  output logic       rx_err
);

  localparam int              TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLOAD    = TW'(TIMEOUT - 1);
  localparam logic [3:0]      LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC-1:0] clk_sync, dat_sync;
  logic            clk_prev;
  logic            clk_s, dat_s, fall;

  ps2_state_t      state, state_nxt;
  logic [3:0]      bit_cnt, cnt_nxt;
  logic [8:0]      shreg, sh_nxt;
  logic [TW-1:0]   timer, timer_nxt;
  logic [7:0]      byte_nxt;
  logic            stb_nxt, err_nxt;

  assign clk_s = clk_sync[SYNC-1];
  assign dat_s = dat_sync[SYNC-1];
  assign fall  = clk_prev & ~clk_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC-2:0], ps2_dat};
      clk_prev <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      timer   <= TLOAD;
      rx_byte <= '0;
      rx_stb  <= 1'b0;
      rx_err  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      shreg   <= sh_nxt;
      timer   <= timer_nxt;
      rx_byte <= byte_nxt;
      rx_stb  <= stb_nxt;
      rx_err  <= err_nxt;
    end
  end

  // Timer is a down-counter reloaded on every edge; an edge in the
  // terminal-count cycle takes priority over the timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    sh_nxt    = shreg;
    timer_nxt = timer;
    byte_nxt  = rx_byte;
    stb_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        timer_nxt = TLOAD;
        if (fall && !dat_s) begin
          state_nxt = SHIFT;
          cnt_nxt   = 4'd1;
        end
      end
      SHIFT: begin
        if (fall) begin
          timer_nxt = TLOAD;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            if ((^shreg) && dat_s) begin
              stb_nxt  = 1'b1;
              byte_nxt = shreg[7:0];
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            sh_nxt  = {dat_s, shreg[8:1]};
            cnt_nxt = bit_cnt + 4'd1;
          end
        end else if (timer == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          err_nxt   = 1'b1;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/jtpopeye_ps2key.sv
// PS/2 keyboard to toggle-word key event: strips E0/F0 prefixes and publishes
// {toggle, pressed, extended, scan code} once per make or break.
module jtpopeye_ps2key
  import jtpopeye_ps2_pkg::*;
#(
  parameter int TIMEOUT = 8000,
  parameter int SYNC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  logic [7:0] rx_byte;
  logic       rx_stb, rx_err;
  logic       ext, brk;

  jtpopeye_ps2_rx #(
    .TIMEOUT (TIMEOUT),
    .SYNC    (SYNC)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .rx_byte (rx_byte),
    .rx_stb  (rx_stb),
    .rx_err  (rx_err)
  );

  assign frame_err = rx_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext     <= 1'b0;
      brk     <= 1'b0;
      ps2_key <= '0;
    end else if (rx_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (rx_stb) begin
      if (rx_byte == PS2_EXT) begin
        ext <= 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk <= 1'b1;
      end else begin
        ps2_key <= {~ps2_key[10], ~brk, ext, rx_byte};
        ext     <= 1'b0;
        brk     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_jtpopeye_ps2key.sv
// Directed bench for jtpopeye_ps2key: table of frames with expected key words
// plus hand sequences for latency, timeout, stray edge and mid-frame reset.
module tb_jtpopeye_ps2key;

  localparam int TO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  jtpopeye_ps2key #(.TIMEOUT(TO), .SYNC(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .ps2_key   (ps2_key),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int err_wide = 0;
  int evt_cnt = 0;
  logic        err_q = 1'b0;
  logic [10:0] key_q = '0;

  always @(negedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (frame_err === 1'b1 && err_q === 1'b1) err_wide++;
    err_q = frame_err;
    if (ps2_key !== key_q) evt_cnt++;
    key_q = ps2_key;
  end

  typedef struct {
    logic [7:0]  code;
    bit          bad_par;
    bit          bad_stop;
    logic [10:0] exp_key;
    int          exp_err;
    int          exp_evt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] c, input bit bad_par, input bit bad_stop);
    return {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
  endfunction

  task automatic ps2_edge(input logic b);
    @(negedge clk) ps2_dat = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic ps2_rise();
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Leaves ps2_clk low after the last bit's falling edge.
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_edge(f[i]);
      if (i < n - 1) ps2_rise();
    end
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 11);
    ps2_rise();
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int e0, v0;

    vecs.push_back('{8'hF0, 1'b0, 1'b0, 11'h614, 0, 0});
    vecs.push_back('{8'h14, 1'b0, 1'b0, 11'h014, 0, 1});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 11'h014, 0, 0});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 11'h775, 0, 1});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 11'h775, 0, 0});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 11'h775, 0, 0});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 11'h175, 0, 1});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 11'h675, 0, 1});
    vecs.push_back('{8'h72, 1'b1, 1'b0, 11'h675, 1, 0});
    vecs.push_back('{8'h72, 1'b0, 1'b0, 11'h272, 0, 1});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 11'h272, 0, 0});
    vecs.push_back('{8'h72, 1'b1, 1'b0, 11'h272, 1, 0});
    vecs.push_back('{8'h72, 1'b0, 1'b0, 11'h672, 0, 1});
    vecs.push_back('{8'hE1, 1'b0, 1'b0, 11'h2E1, 0, 1});
    vecs.push_back('{8'hF0, 1'b0, 1'b0, 11'h2E1, 0, 0});
    vecs.push_back('{8'hAA, 1'b0, 1'b0, 11'h4AA, 0, 1});
    vecs.push_back('{8'hFA, 1'b0, 1'b0, 11'h2FA, 0, 1});
    vecs.push_back('{8'h33, 1'b0, 1'b1, 11'h2FA, 1, 0});
    vecs.push_back('{8'h33, 1'b0, 1'b0, 11'h633, 0, 1});
    vecs.push_back('{8'hE0, 1'b0, 1'b0, 11'h633, 0, 0});
    vecs.push_back('{8'h75, 1'b0, 1'b1, 11'h633, 1, 0});
    vecs.push_back('{8'h75, 1'b0, 1'b0, 11'h275, 0, 1});

    // Reset state
    repeat (4) @(negedge clk);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Make Ctrl with exact latency from the stop-bit edge
    e0 = err_cnt;
    send_bits(mk_frame(8'h14, 1'b0, 1'b0), 11);
    repeat (3) @(posedge clk);
    #1 check("latency_edge3", 32'(ps2_key), 32'h000);
    @(posedge clk);
    #1 check("latency_edge4", 32'(ps2_key), 32'h614);
    ps2_rise();
    repeat (10) @(negedge clk);
    check("make_ctrl_err", 32'(err_cnt - e0), 32'd0);

    foreach (vecs[i]) begin
      e0 = err_cnt;
      v0 = evt_cnt;
      send_frame(mk_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop));
      check($sformatf("vec%0d_key", i), 32'(ps2_key), 32'(vecs[i].exp_key));
      check($sformatf("vec%0d_err", i), 32'(err_cnt - e0), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_evt", i), 32'(evt_cnt - v0), 32'(vecs[i].exp_evt));
    end

    // Falling edge with data high while idle is not a start bit
    e0 = err_cnt;
    ps2_edge(1'b1);
    ps2_rise();
    repeat (10) @(negedge clk);
    check("stray_edge_err", 32'(err_cnt - e0), 32'd0);
    send_frame(mk_frame(8'h0E, 1'b0, 1'b0));
    check("after_stray_key", 32'(ps2_key), 32'h60E);

    // Timeout after a partial frame clears the pending E0
    send_frame(mk_frame(8'hE0, 1'b0, 1'b0));
    e0 = err_cnt;
    send_bits(mk_frame(8'h6B, 1'b0, 1'b0), 5);
    ps2_rise();
    repeat (TO - 30) @(negedge clk);
    check("timeout_early", 32'(err_cnt - e0), 32'd0);
    repeat (60) @(negedge clk);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_key", 32'(ps2_key), 32'h60E);
    send_frame(mk_frame(8'h6B, 1'b0, 1'b0));
    check("after_timeout_key", 32'(ps2_key), 32'h26B);

    // frame_err timing: 3 edges after the offending stop edge
    send_bits(mk_frame(8'h72, 1'b1, 1'b0), 11);
    repeat (2) @(posedge clk);
    #1 check("err_edge2", 32'(frame_err), 32'h0);
    @(posedge clk);
    #1 check("err_edge3", 32'(frame_err), 32'h1);
    @(posedge clk);
    #1 check("err_edge4", 32'(frame_err), 32'h0);
    ps2_rise();
    repeat (10) @(negedge clk);
    check("err_frame_key", 32'(ps2_key), 32'h26B);

    // Reset in the middle of a frame
    e0 = err_cnt;
    send_bits(mk_frame(8'h05, 1'b0, 1'b0), 5);
    ps2_rise();
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midreset_key", 32'(ps2_key), 32'h000);
    send_frame(mk_frame(8'h05, 1'b0, 1'b0));
    check("post_reset_key", 32'(ps2_key), 32'h605);
    check("post_reset_err", 32'(err_cnt - e0), 32'd0);

    check("err_pulse_width", 32'(err_wide), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
